i2c_xact_arbiter: RTL and testbench
===================================

// Module: i2c_xact_arbiter
// PURPOSE
// - Shares one I2C register-transaction engine among NUM_REQ requesters (HDMI TX config, EDID reader, audio codec setup).
// - Round-robin arbitration; the grant is held for one whole transaction (write, or addressed read).
// - Sequences the engine's start/done handshake, returns read data and ACK status to the granted requester.
// - Optionally aborts a hung transaction through a watchdog.
// PARAMETERS
// NUM_REQ         3     number of requesters, 2..8
// TIMEOUT_CYCLES  8192  watchdog limit in clk cycles, counted in WAIT (used only with I2C_ARB_TIMEOUT_EN)
// PORTS
// clk          in   1          system clock; all logic on posedge
// reset        in   1          asynchronous, active-high reset
// req          in   NUM_REQ    per-requester request, held high until its req_done pulse
// req_rnw      in   NUM_REQ    1 = register read, 0 = register write
// req_dev      in   NUM_REQ*7  7-bit I2C device address; requester i uses bits [7i+6:7i]
// req_reg      in   NUM_REQ*8  register address; requester i uses bits [8i+7:8i]
// req_wdata    in   NUM_REQ*8  write data; requester i uses bits [8i+7:8i]
// grant        out  NUM_REQ    one-hot; high from the ISSUE state through the RESP state
// req_done     out  NUM_REQ    one-cycle pulse to the granted requester in RESP
// req_err      out  1          valid with req_done: NACK or timeout
// req_rdata    out  8          valid with req_done; holds its value until the next RESP
// eng_ready    in   1          engine idle, can accept eng_start
// eng_start    out  1          one-cycle start strobe
// eng_rnw      out  1          muxed request fields; driven from the granted index while grant != 0
// eng_dev      out  7          muxed request field
// eng_reg      out  8          muxed request field
// eng_wdata    out  8          muxed request field
// eng_done     in   1          one-cycle completion pulse from the engine
// eng_nack     in   1          valid with eng_done
// eng_rdata    in   8          valid with eng_done
// eng_abort    out  1          one-cycle abort strobe (timeout only); engine returns SCL/SDA high
// BEHAVIOUR
// - Reset values: state=IDLE, grant=0, req_done=0, req_err=0, req_rdata=0, eng_start=0, eng_abort=0, last_idx=NUM_REQ-1.
//   eng_* fields are 0 while grant is 0.
// - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: if any req bit is set, select the first set bit searching last_idx+1, last_idx+2, ... (mod NUM_REQ).
//   Register the selection as idx, set grant[idx], go to ISSUE. The decision takes one cycle.
// - ISSUE: eng_start = eng_ready (combinational from state). On the cycle eng_start is high, go to WAIT.
//   Otherwise stay in ISSUE indefinitely; there is no timeout in ISSUE.
// - WAIT: on eng_done, latch req_rdata (eng_rdata when rnw=1, else 0) and req_err=eng_nack, then go to RESP.
//   An eng_done seen in any other state is ignored.
// - RESP: req_done[idx]=1 for exactly one cycle; last_idx<=idx; grant cleared on exit; go to IDLE.
// - Min latency, req rise to eng_start: 2 cycles.
// - Back-to-back transactions: after RESP there is >=1 IDLE cycle before the next grant.
// - Request fields are sampled through the mux continuously during ISSUE and WAIT.
//   Requesters must hold them stable until req_done.
// - req dropped mid-transaction: the transaction still completes and req_done still pulses. There is no cancel.
// - req still high the cycle after req_done counts as a new request.
// - Simultaneous requests: strict rotation. With all requesters permanently requesting, order is 0,1,2,0,...
// - Reset mid-transaction: all outputs return to reset values asynchronously; no eng_abort is issued.
//   The engine is reset by the same reset.
// CONFIGURATION
// - I2C_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
//   - At count == TIMEOUT_CYCLES-1 with no eng_done: eng_abort=1 for one cycle, req_err=1, req_rdata=0, go to RESP.
//   - eng_done and the timeout in the same cycle: eng_done wins.
// - I2C_ARB_TIMEOUT_EN undefined: no counter; eng_abort is tied 0; WAIT exits only on eng_done.
// TESTING
// - Req0 write dev=0x39 reg=0x41 wdata=0x00, eng_ready=1, engine done after 80 cycles with nack=0
//   -> eng_start 2 cycles after req, grant=001, req_done[0] one cycle, req_err=0.
// - req1 and req2 rise in the same cycle after reset -> req1 served first, then req2.
//   grant goes 010 then 100, with one IDLE cycle between.
// - Req2 read reg=0x42, engine returns rdata=0x40 nack=0 -> req_rdata=0x40 at req_done[2], held after.
// - Engine returns nack=1 for req0 -> req_err=1 with req_done[0]; next request arbitrates normally.
// - I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, engine never done
//   -> eng_abort pulse 64 cycles into WAIT, req_err=1, req_rdata=0.
// - Assert reset during WAIT of a req1 read
//   -> grant=0, req_done=0, eng_start=0 the same cycle; after release, last_idx=NUM_REQ-1 and req0 wins a tie.

Source files
------------

// File: rtl/i2c_xact_arbiter.sv
// rtl/i2c_xact_arbiter.sv - round-robin arbiter sharing one I2C register engine; optional watchdog via I2C_ARB_TIMEOUT_EN
module i2c_xact_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rnw,
  input  logic [NUM_REQ*7-1:0] req_dev,
  input  logic [NUM_REQ*8-1:0] req_reg,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 req_err,
  output logic [7:0]           req_rdata,
  input  logic                 eng_ready,
  output logic                 eng_start,
  output logic                 eng_rnw,
  output logic [6:0]           eng_dev,
  output logic [7:0]           eng_reg,
  output logic [7:0]           eng_wdata,
  input  logic                 eng_done,
  input  logic                 eng_nack,
  input  logic [7:0]           eng_rdata,
  output logic                 eng_abort
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, last_idx, pick;
  logic                 pick_vld;
  logic [NUM_REQ-1:0]   idx_onehot;
  logic [NUM_REQ*7-1:0] dev_sh;
  logic [NUM_REQ*8-1:0] reg_sh, wdata_sh;
  logic                 timeout_hit;

  assign idx_onehot = NUM_REQ'(1) << idx;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Watchdog: zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= '0;
    else if (state != S_WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 16'd1;
  end

  // A completion in the expiry cycle takes priority over the abort.
  assign timeout_hit = (state == S_WAIT) && !eng_done &&
                       (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign eng_abort   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign eng_abort   = 1'b0;
`endif

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [IW-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    // Walk from farthest to nearest so the nearest pending request wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_idx) + k) % NUM_REQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; engine fields follow the grant.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    req_done  = '0;
    eng_start = 1'b0;
    eng_rnw   = 1'b0;
    eng_dev   = '0;
    eng_reg   = '0;
    eng_wdata = '0;
    dev_sh    = req_dev >> (idx * 7);
    reg_sh    = req_reg >> (idx * 8);
    wdata_sh  = req_wdata >> (idx * 8);
    if (state != S_IDLE) begin
      grant     = idx_onehot;
      eng_rnw   = req_rnw[idx];
      eng_dev   = dev_sh[6:0];
      eng_reg   = reg_sh[7:0];
      eng_wdata = wdata_sh[7:0];
    end
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
      S_ISSUE: begin
        eng_start = eng_ready;
        if (eng_ready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (eng_done || timeout_hit) state_nxt = S_RESP;
      S_RESP: begin
        req_done  = idx_onehot;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Selection, rotation pointer and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      last_idx  <= IW'(NUM_REQ - 1);
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (pick_vld) idx <= pick;
        S_WAIT: begin
          if (eng_done) begin
            req_err   <= eng_nack;
            req_rdata <= eng_rnw ? eng_rdata : 8'h00;
          end else if (timeout_hit) begin
            req_err   <= 1'b1;
            req_rdata <= 8'h00;
          end
        end
        S_RESP: last_idx <= idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xact_arbiter.sv
// tb/tb_i2c_xact_arbiter.sv - scoreboard bench for i2c_xact_arbiter with behavioural engine
module tb_i2c_xact_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rnw;
  logic [N*7-1:0] req_dev;
  logic [N*8-1:0] req_reg, req_wdata;
  logic [N-1:0]   grant, req_done;
  logic           req_err;
  logic [7:0]     req_rdata;
  logic           eng_ready, eng_start, eng_rnw, eng_done, eng_nack, eng_abort;
  logic [6:0]     eng_dev;
  logic [7:0]     eng_reg, eng_wdata, eng_rdata;

  always #5 clk = ~clk;

  i2c_xact_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata), .grant(grant), .req_done(req_done),
    .req_err(req_err), .req_rdata(req_rdata), .eng_ready(eng_ready),
    .eng_start(eng_start), .eng_rnw(eng_rnw), .eng_dev(eng_dev), .eng_reg(eng_reg),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_nack(eng_nack),
    .eng_rdata(eng_rdata), .eng_abort(eng_abort)
  );

  typedef struct {
    int         idx;
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    int         lat;
    logic       nack;
    logic [7:0] rdata;
    logic       hang;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    abort_at = 0;
  logic  abort_after = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Queue one transaction: drive requester fields, record expected result and engine reply.
  task automatic post(input int i, input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd, input int lat, input logic nack,
                      input logic [7:0] rd, input logic hang);
    exp_t  e;
    resp_t r;
    req_rnw[i]         = rnw;
    req_dev[i*7 +: 7]  = dev;
    req_reg[i*8 +: 8]  = rg;
    req_wdata[i*8 +: 8] = wd;
    e.idx = i; e.rnw = rnw; e.dev = dev; e.rg = rg; e.wd = wd;
    e.err   = hang ? 1'b1 : nack;
    e.rdata = (hang || !rnw) ? 8'h00 : rd;
    r.lat = lat; r.nack = nack; r.rdata = rd; r.hang = hang;
    exp_q.push_back(e);
    resp_q.push_back(r);
  endtask

  task automatic raise(input logic [N-1:0] m);
    @(posedge clk);
    #2 req = req | m;
  endtask

  task automatic wait_done(input int i, input string tag);
    int t = 0;
    while (!req_done[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(req_done[i]), 32'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || grant != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Behavioural engine: accepts a start, checks muxed fields, replies from resp_q.
  initial begin
    resp_t r;
    exp_t  e;
    int    ew;
    eng_ready = 1'b1; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && eng_start) begin
        if (resp_q.size() == 0 || exp_q.size() == 0) begin
          check("eng_start_unexpected", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          e = exp_q[0];
          check("start_grant", 32'(grant), 32'(1 << e.idx));
          check("start_rnw",   32'(eng_rnw),   32'(e.rnw));
          check("start_dev",   32'(eng_dev),   32'(e.dev));
          check("start_reg",   32'(eng_reg),   32'(e.rg));
          check("start_wdata", 32'(eng_wdata), 32'(e.wd));
          @(posedge clk);
          #1 eng_ready = 1'b0;
          if (r.hang) begin
            ew = 0;
            eng_rdata = 8'h77;
            do begin
              @(negedge clk);
              ew++;
            end while (!eng_abort && !reset && ew < 300);
            abort_at = eng_abort ? ew : 0;
            @(negedge clk);
            abort_after = eng_abort;
            eng_rdata = 8'h00;
            eng_ready = 1'b1;
          end else begin
            repeat (r.lat - 1) @(posedge clk);
            #1 eng_done = 1'b1; eng_nack = r.nack; eng_rdata = r.rdata;
            @(posedge clk);
            #1 eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00; eng_ready = 1'b1;
          end
        end
      end
    end
  end

  // Requesters drop their request right after their done pulse.
  initial begin
    logic [N-1:0] m;
    forever begin
      @(negedge clk);
      if (!reset && req_done != 0) begin
        m = req_done;
        @(posedge clk);
        #1 req = req & ~m;
      end
    end
  end

  // Scoreboard: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && req_done != 0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(req_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_idx",   32'(req_done),  32'(1 << e.idx));
          check("done_grant", 32'(grant),     32'(1 << e.idx));
          check("done_err",   32'(req_err),   32'(e.err));
          check("done_rdata", 32'(req_rdata), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset = 1'b1; req = '0; req_rnw = '1; req_dev = '1; req_reg = '1; req_wdata = '1;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done",  32'(req_done), 32'd0);
    check("rst_err",   32'(req_err), 32'd0);
    check("rst_rdata", 32'(req_rdata), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_abort", 32'(eng_abort), 32'd0);
    check("rst_dev",   32'(eng_dev), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single write, measure request-to-start latency.
    post(0, 1'b0, 7'h39, 8'h41, 8'h00, 80, 1'b0, 8'hA5, 1'b0);
    raise(3'b001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_start && n < 20);
    check("t1_latency", 32'(n), 32'd2);
    check("t1_grant", 32'(grant), 32'b001);
    wait_done(0, "t1_done");
    @(negedge clk);
    check("t1_done_pulse", 32'(req_done), 32'd0);
    wait_quiet("t1_quiet");

    // Simultaneous req1/req2: served 1 then 2 with one IDLE cycle between.
    post(1, 1'b0, 7'h50, 8'h10, 8'h11, 5, 1'b0, 8'h3C, 1'b0);
    post(2, 1'b0, 7'h51, 8'h20, 8'h22, 5, 1'b0, 8'h3D, 1'b0);
    raise(3'b110);
    wait_done(1, "t2_done1");
    @(negedge clk);
    check("t2_idle_gap", 32'(grant), 32'd0);
    @(negedge clk);
    check("t2_grant2", 32'(grant), 32'b100);
    wait_quiet("t2_quiet");

    // Read returning data, held after the pulse.
    post(2, 1'b1, 7'h50, 8'h42, 8'hEE, 12, 1'b0, 8'h40, 1'b0);
    raise(3'b100);
    wait_done(2, "t3_done");
    repeat (3) @(negedge clk);
    check("t3_rdata_hold", 32'(req_rdata), 32'h40);
    wait_quiet("t3_quiet");

    // NACK, then a normal transaction.
    post(0, 1'b1, 7'h39, 8'h43, 8'h00, 6, 1'b1, 8'h12, 1'b0);
    raise(3'b001);
    wait_quiet("t4a_quiet");
    post(1, 1'b0, 7'h4A, 8'h05, 8'h9C, 3, 1'b0, 8'h00, 1'b0);
    raise(3'b010);
    wait_quiet("t4b_quiet");

`ifdef I2C_ARB_TIMEOUT_EN
    // Hung engine: watchdog aborts after 64 WAIT cycles.
    post(2, 1'b1, 7'h1D, 8'h07, 8'h00, 1, 1'b0, 8'h00, 1'b1);
    raise(3'b100);
    wait_quiet("t5_quiet");
    check("t5_abort_at", 32'(abort_at), 32'd64);
    check("t5_abort_one", 32'(abort_after), 32'd0);
`endif

    // Leave last served = 0 so the post-reset tie proves the pointer reset.
    post(0, 1'b0, 7'h39, 8'h60, 8'h61, 4, 1'b0, 8'h00, 1'b0);
    raise(3'b001);
    wait_quiet("t4c_quiet");

    // Reset during WAIT of a req1 read.
    post(1, 1'b1, 7'h50, 8'h33, 8'h00, 1, 1'b0, 8'h00, 1'b1);
    raise(3'b010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_start && n < 20);
    repeat (3) @(negedge clk);
    check("t6_pre_grant", 32'(grant), 32'b010);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_done",  32'(req_done), 32'd0);
    check("t6_rst_start", 32'(eng_start), 32'd0);
    check("t6_rst_abort", 32'(eng_abort), 32'd0);
    check("t6_rst_dev",   32'(eng_dev), 32'd0);
    req = '0;
    exp_q.delete();
    resp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    post(0, 1'b0, 7'h39, 8'h44, 8'h55, 4, 1'b0, 8'h00, 1'b0);
    post(1, 1'b0, 7'h50, 8'h45, 8'h66, 4, 1'b0, 8'h00, 1'b0);
    raise(3'b011);
    wait_quiet("t6_tie_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
